// File: rtl/mlp_sram_arbiter.sv
// Burst-locked two-requester arbiter in front of the single-port weight SRAM.
// Requester 0 is the init loader, requester 1 is the MLP compute FSM.
//
// owner    | meaning
// ---------+-----------------------------------------------------------
// OWN_NONE | port free; round-robin between valid requesters, zero-cycle grant
// OWN_R0   | loader holds the port until a last beat or watchdog release
// OWN_R1   | compute FSM holds the port until a last beat or watchdog release
module mlp_sram_arbiter #(
  parameter int AW        = 11,
  parameter int DW        = 32,
  parameter int MAX_BURST = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [1:0]      req_valid_i,
  output logic [1:0]      req_ready_o,
  input  logic [1:0]      req_we_i,
  input  logic [1:0]      req_last_i,
  input  logic [2*AW-1:0] req_addr_i,
  input  logic [2*DW-1:0] req_wdata_i,
  output logic [1:0]      rsp_valid_o,
  output logic [DW-1:0]   rsp_rdata_o,
  output logic            sram_en_o,
  output logic            sram_we_o,
  output logic [AW-1:0]   sram_addr_o,
  output logic [DW-1:0]   sram_wdata_o,
  input  logic [DW-1:0]   sram_rdata_i
);

  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_R0   = 2'd1,
    OWN_R1   = 2'd2
  } owner_e;

  owner_e          owner_q, owner_d;
  logic            rr_q, rr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      pend_q, pend_d;

  logic            win;
  logic            grant;
  logic [CW-1:0]   cnt_inc;
  logic            rel;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      owner_q <= OWN_NONE;
      rr_q    <= 1'b0;
      cnt_q   <= '0;
      pend_q  <= '0;
    end else begin
      owner_q <= owner_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  // Winner selection and SRAM drive; the accepted beat goes to the macro the same cycle.
  always_comb begin
    win   = 1'b0;
    grant = 1'b0;
    case (owner_q)
      OWN_R0: begin
        win   = 1'b0;
        grant = req_valid_i[0];
      end
      OWN_R1: begin
        win   = 1'b1;
        grant = req_valid_i[1];
      end
      default: begin
        grant = |req_valid_i;
        win   = (req_valid_i == 2'b11) ? rr_q : req_valid_i[1];
      end
    endcase

    req_ready_o  = 2'b00;
    sram_en_o    = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    if (grant) begin
      req_ready_o  = win ? 2'b10 : 2'b01;
      sram_en_o    = 1'b1;
      sram_we_o    = req_we_i[win];
      sram_addr_o  = win ? req_addr_i[AW +: AW] : req_addr_i[0 +: AW];
      sram_wdata_o = win ? req_wdata_i[DW +: DW] : req_wdata_i[0 +: DW];
    end
  end

  // Release on a last beat or when the burst hits the watchdog limit.
  always_comb begin
    owner_d = owner_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    pend_d  = 2'b00;
    cnt_inc = cnt_q + 1'b1;
    rel     = req_last_i[win] || (cnt_inc == CW'(MAX_BURST));
    if (grant) begin
      if (!req_we_i[win]) pend_d = win ? 2'b10 : 2'b01;
      if (rel) begin
        owner_d = OWN_NONE;
        cnt_d   = '0;
        rr_d    = ~win;
      end else begin
        owner_d = win ? OWN_R1 : OWN_R0;
        cnt_d   = cnt_inc;
      end
    end
  end

  assign rsp_valid_o = pend_q;
  assign rsp_rdata_o = sram_rdata_i;

endmodule
